// File: rtl/audio_adc_rx.sv
// Codec ADC receiver: oversamples a left-justified I2S-style stream on the system clock
// and presents complete stereo frames over a valid/ready handshake with overrun tracking.
`timescale 1ns/1ps
module audio_adc_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  aud_bclk,
  input  logic                  aud_adclrck,
  input  logic                  aud_adcdat,
  input  logic                  enable,
  input  logic                  sample_ready,
  input  logic                  clear_overrun,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic [DATA_WIDTH-1:0] sample_right,
  output logic                  sample_valid,
  output logic                  overrun,
  output logic                  frame_error
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEFT_SHIFT,
    LEFT_WAIT,
    RIGHT_SHIFT,
    RIGHT_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q, dat_sync_q;
  logic                   bclk_prev_q, lrck_prev_q, lrck_seen_q;
  logic                   bclk_s, lrck_s, dat_s;
  logic                   bclk_rise, lr_edge, lr_rise, lr_fall;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0]  shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic [DATA_WIDTH-1:0]  shifted_l, shifted_r;
  logic                   commit, short_err;

  logic [DATA_WIDTH-1:0]  left_q, right_q;
  logic                   valid_q, overrun_q, frame_error_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      lrck_seen_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], aud_bclk};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], aud_adclrck};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], aud_adcdat};
      bclk_prev_q <= bclk_s;
      if (bclk_rise) begin
        lrck_prev_q <= lrck_s;
        lrck_seen_q <= 1'b1;
      end
    end
  end

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  // The first sample after reset has no predecessor, so it can never form an edge.
  assign lr_edge   = bclk_rise & lrck_seen_q & (lrck_s ^ lrck_prev_q);
  assign lr_rise   = lr_edge & lrck_s;
  assign lr_fall   = lr_edge & ~lrck_s;

  assign shifted_l = {shift_l_q[DATA_WIDTH-2:0], dat_s};
  assign shifted_r = {shift_r_q[DATA_WIDTH-2:0], dat_s};
  assign cnt_inc   = bit_cnt_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    commit    = 1'b0;
    short_err = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else if (bclk_rise) begin
      unique case (state_q)
        IDLE: begin
          if (lr_rise) begin
            shift_l_d = shifted_l;
            bit_cnt_d = CNT_W'(1);
            state_d   = LEFT_SHIFT;
          end
        end
        LEFT_SHIFT, RIGHT_SHIFT: begin
          if (lr_edge) begin
            short_err = 1'b1;
            if (lr_rise) begin
              shift_l_d = shifted_l;
              bit_cnt_d = CNT_W'(1);
              state_d   = LEFT_SHIFT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = cnt_inc;
            if (state_q == LEFT_SHIFT) begin
              shift_l_d = shifted_l;
              if (cnt_inc == CNT_W'(DATA_WIDTH)) state_d = LEFT_WAIT;
            end else begin
              shift_r_d = shifted_r;
              if (cnt_inc == CNT_W'(DATA_WIDTH)) begin
                commit  = 1'b1;
                state_d = RIGHT_WAIT;
              end
            end
          end
        end
        LEFT_WAIT: begin
          if (lr_fall) begin
            shift_r_d = shifted_r;
            bit_cnt_d = CNT_W'(1);
            state_d   = RIGHT_SHIFT;
          end
        end
        RIGHT_WAIT: begin
          if (lr_rise) begin
            shift_l_d = shifted_l;
            bit_cnt_d = CNT_W'(1);
            state_d   = LEFT_SHIFT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_l_q <= '0;
      shift_r_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
    end
  end

  // Output side: a commit always wins over acceptance, so a simultaneous
  // ready+commit hands off the old frame and presents the new one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_q        <= '0;
      right_q       <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_error_q <= short_err;
      if (commit) begin
        left_q  <= shift_l_q;
        right_q <= shifted_r;
        valid_q <= 1'b1;
      end else if (sample_ready) begin
        valid_q <= 1'b0;
      end
      if (commit && valid_q && !sample_ready) overrun_q <= 1'b1;
      else if (clear_overrun)                 overrun_q <= 1'b0;
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Self-checking bench for audio_adc_rx: drives a bit-level codec stream and compares
// accepted frames and frame-error pulses against a frame-level expectation model.
`timescale 1ns/1ps
module tb_audio_adc_rx;
  localparam int DW = 16;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          aud_bclk = 1'b0, aud_adclrck = 1'b0, aud_adcdat = 1'b0;
  logic          enable = 1'b0, sample_ready = 1'b0, clear_overrun = 1'b0;
  logic [DW-1:0] sample_left, sample_right;
  logic          sample_valid, overrun, frame_error;

  int total = 0, bad = 0;
  int err_seen = 0, err_exp = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] mon_e;
  logic [DW-1:0]   hold_l, hold_r;

  audio_adc_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck), .aud_adcdat(aud_adcdat),
    .enable(enable), .sample_ready(sample_ready), .clear_overrun(clear_overrun),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .overrun(overrun), .frame_error(frame_error)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every accepted frame must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (frame_error) err_seen++;
    if (sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 64'(sample_valid), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_left", 64'(sample_left), 64'(mon_e[2*DW-1:DW]));
        check("frame_right", 64'(sample_right), 64'(mon_e[DW-1:0]));
      end
    end
  end

  task automatic bclk_bit(input bit lr, input bit d);
    aud_bclk    = 1'b0;
    aud_adclrck = lr;
    aud_adcdat  = d;
    #42;
    aud_bclk = 1'b1;
    #41;
  endtask

  task automatic send_half(input bit lr, input logic [DW-1:0] data, input int slot);
    for (int i = 0; i < slot; i++)
      bclk_bit(lr, (i < DW) ? data[DW-1-i] : 1'($urandom));
  endtask

  // Frame-level model: a left slot shorter than DW is one error and the right slot
  // is ignored; a short right slot is one error (seen at the next left start);
  // otherwise the frame is delivered intact.
  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int ls, input int rs, input bit model);
    if (model) begin
      if (ls < DW)      err_exp++;
      else if (rs < DW) err_exp++;
      else              exp_q.push_back({l, r});
    end
    send_half(1'b1, l, ls);
    send_half(1'b0, r, rs);
  endtask

  task automatic set_ready(input bit v);
    @(posedge clk);
    #1 sample_ready = v;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rl, rr;
    int ls, rs;

    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_left", 64'(sample_left), 64'(0));
    check("rst_right", 64'(sample_right), 64'(0));
    check("rst_valid", 64'(sample_valid), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_frame_error", 64'(frame_error), 64'(0));
    reset_n      = 1'b1;
    sample_ready = 1'b1;

    // Stream starts in the middle of a right slot: nothing may come out.
    send_half(1'b0, DW'($urandom), 10);
    repeat (20) @(posedge clk);
    #1 check("mid_right_no_valid", 64'(sample_valid), 64'(0));

    send_frame(16'h8001, 16'h7FFE, 32, 32, 1'b1);
    send_frame(16'h1234, 16'h5678, 10, 32, 1'b1);
    send_frame(16'h0F0F, 16'hF0F0, 32, 32, 1'b1);

    for (int n = 0; n < 14; n++) begin
      rl = DW'($urandom);
      rr = DW'($urandom);
      ls = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, DW-1)) : int'($urandom_range(DW, 32));
      rs = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, DW-1)) : int'($urandom_range(DW, 32));
      send_frame(rl, rr, ls, rs, 1'b1);
    end
    send_frame(DW'($urandom), DW'($urandom), DW, DW, 1'b1);
    repeat (20) @(posedge clk);

    // Back-pressure: three frames with ready low.
    set_ready(1'b0);
    send_frame(16'h1111, 16'hAAA1, 32, 32, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp1_valid", 64'(sample_valid), 64'(1));
    check("bp1_overrun", 64'(overrun), 64'(0));
    check("bp1_left", 64'(sample_left), 64'(16'h1111));
    send_frame(16'h2222, 16'hAAA2, 32, 32, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp2_overrun", 64'(overrun), 64'(1));
    check("bp2_left", 64'(sample_left), 64'(16'h2222));
    send_frame(16'h3333, 16'hAAA3, 32, 32, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp3_valid", 64'(sample_valid), 64'(1));
    check("bp3_left", 64'(sample_left), 64'(16'h3333));
    check("bp3_right", 64'(sample_right), 64'(16'hAAA3));
    @(posedge clk);
    #1 clear_overrun = 1'b1;
    @(posedge clk);
    #1 clear_overrun = 1'b0;
    @(negedge clk);
    check("clear_overrun", 64'(overrun), 64'(0));
    check("clear_keeps_valid", 64'(sample_valid), 64'(1));
    exp_q.push_back({16'h3333, 16'hAAA3});
    set_ready(1'b1);
    repeat (5) @(posedge clk);

    // Enable dropped mid-left: partial frame discarded, outputs held.
    hold_l = sample_left;
    hold_r = sample_right;
    fork
      send_frame(16'hC3C3, 16'h3C3C, 32, 32, 1'b0);
      begin
        #(4 * 83);
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("dis_hold_left", 64'(sample_left), 64'(hold_l));
        check("dis_hold_right", 64'(sample_right), 64'(hold_r));
        check("dis_valid", 64'(sample_valid), 64'(0));
        @(posedge clk);
        #1 enable = 1'b1;
      end
    join
    send_frame(16'h1357, 16'h2468, 32, 32, 1'b1);

    // Reset during the right slot.
    fork
      send_frame(16'hFFFF, 16'hFFFF, 32, 32, 1'b0);
      begin
        #((32 + 5) * 83 + 20);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_left", 64'(sample_left), 64'(0));
        check("mid_rst_right", 64'(sample_right), 64'(0));
        check("mid_rst_valid", 64'(sample_valid), 64'(0));
        #100;
        @(negedge clk);
        reset_n = 1'b1;
      end
    join
    send_frame(16'hA5A5, 16'h5A5A, 32, 32, 1'b1);
    repeat (30) @(posedge clk);
    @(negedge clk);

    check("frames_outstanding", 64'(exp_q.size()), 64'(0));
    check("frame_error_count", 64'(err_seen), 64'(err_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
